// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor: X - Y computed LSB first, one bit per clk, fixed latency.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB4_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | four cycles of serial subtract, LSB first
// DONE  | one-cycle done pulse; start here launches the next operation directly
module serial_sub4 (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  output logic o0,
  output logic o1,
  output logic o2,
  output logic o3,
  output logic borrow,
  output logic busy,
  output logic done
`ifdef SERIAL_SUB4_OVF_EN
  ,
  output logic ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  logic [3:0] sa;
  logic [3:0] sb;
  logic [3:0] dacc;
  logic       bin;
  logic [1:0] cnt;
  logic       a;
  logic       b;
  logic       d;
  logic       bout;
`ifdef SERIAL_SUB4_OVF_EN
  logic       xm;
  logic       ym;
`endif

  assign a    = sa[0];
  assign b    = sb[0];
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      sa               <= 4'd0;
      sb               <= 4'd0;
      dacc             <= 4'd0;
      bin              <= 1'b0;
      cnt              <= 2'd0;
      {o0, o1, o2, o3} <= 4'd0;
      borrow           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
      xm               <= 1'b0;
      ym               <= 1'b0;
      ovf              <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= {x0, x1, x2, x3};
            sb    <= {y0, y1, y2, y3};
            dacc  <= 4'd0;
            bin   <= 1'b0;
            cnt   <= 2'd0;
            state <= SHIFT;
            busy  <= 1'b1;
`ifdef SERIAL_SUB4_OVF_EN
            xm    <= x0;
            ym    <= y0;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          dacc <= {d, dacc[3:1]};
          bin  <= bout;
          cnt  <= cnt + 2'd1;
          // Final bit: commit the difference together with the MSB just produced.
          if (cnt == 2'd3) begin
            {o0, o1, o2, o3} <= {d, dacc[3:1]};
            borrow           <= bout;
            state            <= DONE;
            done             <= 1'b1;
`ifdef SERIAL_SUB4_OVF_EN
            ovf              <= (xm != ym) & (d != xm);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Randomized self-checking bench for serial_sub4 against an arithmetic reference model.
// Define SERIAL_SUB4_OVF_EN for both files to exercise the overflow output.
module tb_serial_sub4;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic x0, x1, x2, x3;
  logic y0, y1, y2, y3;
  logic o0, o1, o2, o3;
  logic borrow;
  logic busy;
  logic done;
`ifdef SERIAL_SUB4_OVF_EN
  logic ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] hold_o;
  logic       hold_b;
  logic       hold_v;

  always #5 clk = ~clk;

  serial_sub4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x0     (x0),
    .x1     (x1),
    .x2     (x2),
    .x3     (x3),
    .y0     (y0),
    .y1     (y1),
    .y2     (y2),
    .y3     (y3),
    .o0     (o0),
    .o1     (o1),
    .o2     (o2),
    .o3     (o3),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
`ifdef SERIAL_SUB4_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ovf_ref(input logic [3:0] x, input logic [3:0] y);
    int sx;
    int sy;
    sx = (x >= 8) ? int'(x) - 16 : int'(x);
    sy = (y >= 8) ? int'(y) - 16 : int'(y);
    return ((sx - sy) > 7) || ((sx - sy) < -8);
  endfunction

  task automatic drive_xy(input logic [3:0] x, input logic [3:0] y);
    {x0, x1, x2, x3} = x;
    {y0, y1, y2, y3} = y;
  endtask

  task automatic drive_rand();
    drive_xy(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_o"}, {o0, o1, o2, o3}, hold_o);
    check({tag, "_borrow"}, borrow, hold_b);
`ifdef SERIAL_SUB4_OVF_EN
    check({tag, "_ovf"}, ovf, hold_v);
`endif
  endtask

  // One complete operation; mid pulses start during the 2nd SHIFT cycle, which must be ignored.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input bit mid);
    logic [3:0] eo;
    logic       eb;
    logic       ev;
    eo = (x - y) & 4'hf;
    eb = (x < y);
    ev = ovf_ref(x, y);
    @(posedge clk); #1;
    start = 1'b1;
    drive_xy(x, y);
    @(posedge clk); #1;
    start = 1'b0;
    drive_rand();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("shift_busy", busy, 1);
      check("shift_done", done, 0);
      check_outputs("shift_hold");
      start = (mid && i == 2);
      drive_rand();
      @(posedge clk); #1;
    end
    @(negedge clk);
    hold_o = eo;
    hold_b = eb;
    hold_v = ev;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check_outputs("result");
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check_outputs("idle_hold");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive_xy(4'd0, 4'd0);
    hold_o = 4'd0;
    hold_b = 1'b0;
    hold_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outputs("rst");
    rst_n = 1'b1;

    run_op(4'b0111, 4'b0011, 1'b0);
    run_op(4'b0011, 4'b0111, 1'b0);
    run_op(4'b1000, 4'b0001, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b0);
    run_op(4'b0000, 4'b0001, 1'b0);
    run_op(4'b1001, 4'b0110, 1'b1);

    // start held high: back-to-back operations, done every 5th cycle
    @(posedge clk); #1;
    start = 1'b1;
    drive_xy(4'b0101, 4'b0010);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("cont_busy", busy, 1);
      check("cont_done", done, (k % 5) == 0);
      if ((k % 5) == 0) begin
        hold_o = 4'b0011;
        hold_b = 1'b0;
        hold_v = 1'b0;
        check_outputs("cont_result");
      end
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cont_end_busy", busy, 0);

    // reset on the 3rd SHIFT edge aborts the operation
    @(posedge clk); #1;
    start = 1'b1;
    drive_xy(4'b1100, 4'b0001);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    hold_o = 4'd0;
    hold_b = 1'b0;
    hold_v = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_outputs("abort");
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    run_op(4'b1010, 4'b0101, 1'b0);

    // reset wins over start on the same edge
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    hold_o = 4'd0;
    hold_b = 1'b0;
    hold_v = 1'b0;
    check("prio_busy", busy, 0);
    check_outputs("prio");
    rst_n = 1'b1;
    start = 1'b0;

    for (int n = 0; n < 25; n++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
